// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed 8-digit 7-segment scan and publishes decoded frames.
module seg_scan_decoder #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  an,
  input  logic [7:0]  duan,
  input  logic [7:0]  duan1,
  output logic [39:0] digits,
  output logic [7:0]  dps,
  output logic        frame_done,
  output logic        frame_valid,
  output logic        stale,
  output logic        bad_an
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HELD} state_t;
  state_t state, state_n;
  logic [7:0] an_q, mask, mask_n, seg, shadow_dp, shadow_dp_n;
  logic [39:0] shadow, shadow_n;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idle;
  logic [4:0] code;
  logic [2:0] k;
  logic chg, sample, one_hot, multi, timeout_hit;
  function automatic logic [4:0] dec(input logic [6:0] s);
    case (s)
      7'h3F: dec = 5'h00;
      7'h06: dec = 5'h01;
      7'h5B: dec = 5'h02;
      7'h4F: dec = 5'h03;
      7'h66: dec = 5'h04;
      7'h6D: dec = 5'h05;
      7'h7D: dec = 5'h06;
      7'h07: dec = 5'h07;
      7'h7F: dec = 5'h08;
      7'h6F: dec = 5'h09;
      7'h77: dec = 5'h0A;
      7'h7C: dec = 5'h0B;
      7'h39: dec = 5'h0C;
      7'h5E: dec = 5'h0D;
      7'h79: dec = 5'h0E;
      7'h71: dec = 5'h0F;
      7'h00: dec = 5'h10;
      7'h40: dec = 5'h11;
      default: dec = 5'h1F;
    endcase
  endfunction
  assign chg         = an != an_q;
  assign sample      = state == S_SETTLE && !chg && cnt == CW'(SETTLE - 1);
  assign multi       = (an & (an - 8'd1)) != 8'd0;
  assign one_hot     = an != 8'd0 && !multi;
  assign timeout_hit = !chg && idle == IW'(TIMEOUT - 1);
  assign seg         = k[2] ? duan1 : duan;
  assign code        = dec(seg[6:0]);
  always_comb begin
    state_n = chg ? S_SETTLE : sample ? S_HELD : state;
    k = '0;
    for (int i = 0; i < 8; i++)
      if (an[i]) k = 3'(i);
    shadow_n = shadow;
    shadow_n[5*k +: 5] = code;
    shadow_dp_n = shadow_dp;
    shadow_dp_n[k] = seg[7];
    mask_n = mask | (8'd1 << k);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      an_q        <= '0;
      cnt         <= '0;
      idle        <= '0;
      mask        <= '0;
      shadow      <= '0;
      shadow_dp   <= '0;
      digits      <= '0;
      dps         <= '0;
      frame_done  <= 1'b0;
      frame_valid <= 1'b0;
      stale       <= 1'b0;
      bad_an      <= 1'b0;
    end else begin
      state      <= state_n;
      an_q       <= an;
      cnt        <= chg ? CW'(1) : cnt != CW'(SETTLE) ? cnt + CW'(1) : cnt;
      idle       <= chg ? '0 : idle != IW'(TIMEOUT) ? idle + IW'(1) : idle;
      frame_done <= 1'b0;
      if (timeout_hit) begin
        stale       <= 1'b1;
        frame_valid <= 1'b0;
        mask        <= '0;
      end
      if (sample && multi) bad_an <= 1'b1;
      // a completing capture publishes the shadow including the digit written on this edge
      if (sample && one_hot) begin
        shadow    <= shadow_n;
        shadow_dp <= shadow_dp_n;
        mask      <= &mask_n ? 8'h00 : mask_n;
        if (&mask_n) begin
          digits      <= shadow_n;
          dps         <= shadow_dp_n;
          frame_done  <= 1'b1;
          frame_valid <= 1'b1;
          stale       <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE, default 4: number of consecutive cycles an must hold one value before it is sampled.
REQ-002 Parameter TIMEOUT, default 1000000: number of idle cycles before the display is declared stale.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 an  input  8  digit select, active-high; an[3:0] selects right-bank digits 0-3 and an[7:4] selects left-bank digits 4-7.
REQ-006 duan  input  8  segments for the right bank, active-high: bit0=a through bit6=g, bit7=dp.
REQ-007 duan1  input  8  segments for the left bank, same bit order as duan.
REQ-008 digits  output  40  eight 5-bit codes; digit k occupies bits [5k+4:5k].
REQ-009 dps  output  8  decimal point per digit.
REQ-010 frame_done  output  1  one-cycle pulse when a complete frame is published.
REQ-011 frame_valid  output  1  level; digits and dps hold a complete frame.
REQ-012 stale  output  1  level; scan activity lost.
REQ-013 bad_an  output  1  sticky; a multi-hot an value was seen.

Function
REQ-014 Stability tracking: the block SHALL register an; any change of an SHALL restart the stability count at 1.
REQ-015 A sample SHALL be taken on the edge where an has held an unchanged value for SETTLE consecutive cycles.
- Exactly one sample per stable period, no re-sampling while an stays unchanged.
REQ-016 State machine, states IDLE, SETTLE, HELD:
- IDLE -> SETTLE on an change.
- SETTLE -> HELD when the count reaches SETTLE (the sample edge).
- Any state -> SETTLE on an change.
- HELD persists until an changes.
REQ-017 Sample action on a one-hot an selecting digit k:
- Segments come from duan for k<4 and from duan1 for k>=4.
- The decoded code is written to shadow[k] and dp to shadow_dp[k].
- Bit k of capture mask is set.
REQ-018 Decode table, bits g..a:
- 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=B, 39=C, 5E=D, 79=E, 71=F.
- 00=0x10 (blank), 40=0x11 (minus).
- Any other pattern=0x1F.
- dp is excluded from the table lookup.
REQ-019 Recapture of digit k before the frame completes SHALL overwrite shadow[k] (latest value wins).
REQ-020 Frame completion: on the sample edge where the mask becomes 8'hFF, the block SHALL, on that same edge:
- copy shadow to digits and dps,
- clear the mask,
- set frame_valid,
- assert frame_done for exactly one cycle.
REQ-021 an = 8'h00 held for SETTLE cycles SHALL cause no capture and no error.
REQ-022 an with two or more bits set, held for SETTLE cycles, SHALL cause no capture and SHALL set bad_an; bad_an is cleared only by rst.
REQ-023 Idle counter:
- Increments each cycle an is unchanged; saturates at TIMEOUT.
- Clears on any an change.
REQ-024 On reaching TIMEOUT, the block SHALL set stale, clear frame_valid and clear the capture mask; digits and dps SHALL retain their last values.
REQ-025 stale SHALL clear on the next frame_done.
REQ-026 digits and dps SHALL change only on frame_done edges or on rst.

Reset
REQ-027 rst asserted SHALL on the next edge clear:
- digits to 0, dps to 0, the shadow registers, and the capture mask;
- frame_done, frame_valid, stale and bad_an to 0;
- both counters to 0, and the state machine to IDLE.
REQ-028 rst applied mid-frame SHALL discard all partial captures; the first frame after reset SHALL require all eight digits to be captured again.

Verification
REQ-029 Scan 8 digits one-hot an=01,02,..80, each held 10 cycles, with duan=3F,06,5B,4F and duan1=66,6D,7D,07 -> after the last digit settles, one frame_done pulse; digits codes 0..7; frame_valid=1.
REQ-030 an glitches between digits that last fewer than SETTLE cycles -> no capture of the glitch value; digits identical to the clean scan.
REQ-031 an=03 held 20 cycles -> bad_an=1, no capture; a following clean frame still produces frame_done, and bad_an stays 1.
REQ-032 Digit 2 captured as 5B, then recaptured as 00 before the frame completes -> published code for digit 2 is 0x10.
REQ-033 With TIMEOUT=50, hold an=01 for 60 cycles after a valid frame -> stale=1 at cycle 50, frame_valid=0, digits unchanged; a new full scan -> frame_done, stale=0.
REQ-034 rst after 5 digits are captured, then scan digits 5-7 only -> no frame_done; a subsequent full 8-digit scan -> frame_done.
